// File: rtl/register_bank.sv
// Bank of NUM_REGS registers sharing one tristate data bus.
// The selected register can be loaded from the bus, incremented, decremented or read onto the bus.
module register_bank #(
    parameter int                DATA_W      = 32,
    parameter int                NUM_REGS    = 4,
    parameter int                SEL_W       = $clog2(NUM_REGS),
    parameter logic [DATA_W-1:0] RESET_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         oe,
    input  logic [SEL_W-1:0]             sel,
    input  logic [1:0]                   op,
    inout  wire  [DATA_W-1:0]            data_bus,
    output logic [NUM_REGS*DATA_W-1:0]   register_state,
    output logic                         wrap,
    output logic                         zero,
    output logic                         sel_err,
    output logic                         bus_conflict
);

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_INC  = 2'b10;
    localparam logic [1:0] OP_DEC  = 2'b11;

    localparam logic [SEL_W:0] NUM_REGS_EXT = NUM_REGS[SEL_W:0];

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] sel_val;

    assign sel_err = ({1'b0, sel} >= NUM_REGS_EXT);

    // An out-of-range select matches no register, so sel_val falls back to zero.
    always_comb begin
        sel_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_val = regs[i];
            end
        end
    end

    assign data_bus     = oe ? sel_val : {DATA_W{1'bz}};
    assign zero         = !sel_err && (sel_val == '0);
    assign bus_conflict = oe && (op == OP_LOAD);

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign register_state[g*DATA_W +: DATA_W] = regs[g];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VALUE;
            end
            wrap <= 1'b0;
        end else if (!sel_err) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (sel == SEL_W'(i)) begin
                    case (op)
                        // With oe set the bus carries this register itself, so the load is a no-op.
                        OP_LOAD: if (!oe) regs[i] <= data_bus;
                        OP_INC:  regs[i] <= regs[i] + DATA_W'(1);
                        OP_DEC:  regs[i] <= regs[i] - DATA_W'(1);
                        default: regs[i] <= regs[i];
                    endcase
                end
            end
            case (op)
                OP_INC:  wrap <= (sel_val == '1);
                OP_DEC:  wrap <= (sel_val == '0);
                OP_HOLD: wrap <= wrap;
                default: wrap <= wrap;
            endcase
        end
    end

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank: an 8-bit four-register bank and a three-register bank
// exercising reset, load, wrap, invalid select, async reset and back-to-back operations.
module tb_register_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        oe4 = 1'b0;
    logic [1:0]  sel4 = '0;
    logic [1:0]  op4 = '0;
    logic        drv4_en = 1'b0;
    logic [7:0]  drv4 = '0;
    wire  [7:0]  bus4;
    logic [31:0] rs4;
    logic        wrap4, zero4, sel_err4, conflict4;

    logic        oe3 = 1'b0;
    logic [1:0]  sel3 = '0;
    logic [1:0]  op3 = '0;
    logic        drv3_en = 1'b0;
    logic [7:0]  drv3 = '0;
    wire  [7:0]  bus3;
    logic [23:0] rs3;
    logic        wrap3, zero3, sel_err3, conflict3;

    int checks = 0;
    int errors = 0;

    assign bus4 = drv4_en ? drv4 : 8'bz;
    assign bus3 = drv3_en ? drv3 : 8'bz;

    always #5 clk = ~clk;

    register_bank #(.DATA_W(8), .NUM_REGS(4), .RESET_VALUE(8'h5A)) dut4 (
        .clk(clk), .rst(rst), .oe(oe4), .sel(sel4), .op(op4), .data_bus(bus4),
        .register_state(rs4), .wrap(wrap4), .zero(zero4), .sel_err(sel_err4),
        .bus_conflict(conflict4)
    );

    register_bank #(.DATA_W(8), .NUM_REGS(3), .RESET_VALUE(8'h5A)) dut3 (
        .clk(clk), .rst(rst), .oe(oe3), .sel(sel3), .op(op3), .data_bus(bus3),
        .register_state(rs3), .wrap(wrap3), .zero(zero3), .sel_err(sel_err3),
        .bus_conflict(conflict3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        oe4 = 1'b1;
        sel4 = 2'd1;
        #1;
        checks++;
        if (rs4 !== 32'h5A5A5A5A) begin errors++; $display("FAIL reset_state got %h want %h", rs4, 32'h5A5A5A5A); end
        checks++;
        if (wrap4 !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", wrap4); end
        checks++;
        if (bus4 !== 8'h5A) begin errors++; $display("FAIL reset_bus_oe got %h want 5a", bus4); end
        checks++;
        if (rs3 !== 24'h5A5A5A) begin errors++; $display("FAIL reset_state3 got %h want 5a5a5a", rs3); end
        @(negedge clk);
        rst = 1'b1;
        oe4 = 1'b0;
        drv4_en = 1'b1;
        drv4 = 8'hA5;
        #1;
        // DUT released the bus: the bench's value is seen undisturbed.
        checks++;
        if (bus4 !== 8'hA5) begin errors++; $display("FAIL reset_bus_released got %h want a5", bus4); end
        checks++;
        if (sel_err4 !== 1'b0 || zero4 !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b want 00", sel_err4, zero4); end
        drv4_en = 1'b0;
    endtask

    task automatic test_load();
        @(negedge clk);
        drv4_en = 1'b1; drv4 = 8'h3C; sel4 = 2'd2; op4 = 2'b01; oe4 = 1'b0;
        tick();
        checks++;
        if (rs4 !== 32'h5A3C5A5A) begin errors++; $display("FAIL load_state got %h want 5a3c5a5a", rs4); end
        @(negedge clk);
        drv4_en = 1'b0; op4 = 2'b00; oe4 = 1'b1;
        #1;
        checks++;
        if (bus4 !== 8'h3C) begin errors++; $display("FAIL load_read_bus got %h want 3c", bus4); end
        @(negedge clk);
        op4 = 2'b01;
        #1;
        checks++;
        if (conflict4 !== 1'b1) begin errors++; $display("FAIL load_conflict got %b want 1", conflict4); end
        tick();
        checks++;
        if (rs4 !== 32'h5A3C5A5A) begin errors++; $display("FAIL load_suppressed got %h want 5a3c5a5a", rs4); end
        @(negedge clk);
        op4 = 2'b00; oe4 = 1'b0;
        #1;
        checks++;
        if (conflict4 !== 1'b0) begin errors++; $display("FAIL conflict_clear got %b want 0", conflict4); end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        drv4_en = 1'b1; drv4 = 8'hFE; sel4 = 2'd1; op4 = 2'b01;
        tick();
        @(negedge clk);
        drv4_en = 1'b0; op4 = 2'b10;
        tick();
        checks++;
        if (rs4[15:8] !== 8'hFF || wrap4 !== 1'b0) begin errors++; $display("FAIL wrap_inc1 got %h/%b want ff/0", rs4[15:8], wrap4); end
        tick();
        checks++;
        if (rs4[15:8] !== 8'h00 || wrap4 !== 1'b1) begin errors++; $display("FAIL wrap_inc2 got %h/%b want 00/1", rs4[15:8], wrap4); end
        checks++;
        if (zero4 !== 1'b1) begin errors++; $display("FAIL wrap_zero got %b want 1", zero4); end
        @(negedge clk);
        op4 = 2'b00;
        tick();
        checks++;
        if (wrap4 !== 1'b1) begin errors++; $display("FAIL wrap_hold got %b want 1", wrap4); end
        @(negedge clk);
        op4 = 2'b11;
        tick();
        checks++;
        if (rs4[15:8] !== 8'hFF || wrap4 !== 1'b1) begin errors++; $display("FAIL wrap_dec1 got %h/%b want ff/1", rs4[15:8], wrap4); end
        tick();
        checks++;
        if (rs4 !== 32'h5A3CFE5A || wrap4 !== 1'b0) begin errors++; $display("FAIL wrap_dec2 got %h/%b want 5a3cfe5a/0", rs4, wrap4); end
        @(negedge clk);
        op4 = 2'b00;
    endtask

    task automatic test_sel_err();
        @(negedge clk);
        drv3_en = 1'b1; drv3 = 8'h00; sel3 = 2'd0; op3 = 2'b01;
        tick();
        @(negedge clk);
        drv3_en = 1'b0; op3 = 2'b11;
        tick();
        checks++;
        if (rs3 !== 24'h5A5AFF || wrap3 !== 1'b1) begin errors++; $display("FAIL selerr_setup got %h/%b want 5a5aff/1", rs3, wrap3); end
        @(negedge clk);
        sel3 = 2'd3; op3 = 2'b10; oe3 = 1'b1;
        #1;
        checks++;
        if (sel_err3 !== 1'b1) begin errors++; $display("FAIL selerr_flag got %b want 1", sel_err3); end
        checks++;
        if (bus3 !== 8'h00) begin errors++; $display("FAIL selerr_bus got %h want 00", bus3); end
        checks++;
        if (zero3 !== 1'b0) begin errors++; $display("FAIL selerr_zero got %b want 0", zero3); end
        tick();
        checks++;
        if (rs3 !== 24'h5A5AFF || wrap3 !== 1'b1) begin errors++; $display("FAIL selerr_nochange got %h/%b want 5a5aff/1", rs3, wrap3); end
        @(negedge clk);
        op3 = 2'b00; oe3 = 1'b0; sel3 = 2'd0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        sel4 = 2'd0; op4 = 2'b10; oe4 = 1'b0;
        tick();
        tick();
        checks++;
        if (rs4[7:0] !== 8'h5C) begin errors++; $display("FAIL async_pre got %h want 5c", rs4[7:0]); end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (rs4 !== 32'h5A5A5A5A || wrap4 !== 1'b0) begin errors++; $display("FAIL async_mid got %h/%b want 5a5a5a5a/0", rs4, wrap4); end
        @(negedge clk);
        rst = 1'b1;
        tick();
        checks++;
        if (rs4 !== 32'h5A5A5A5B) begin errors++; $display("FAIL async_resume got %h want 5a5a5a5b", rs4); end
        @(negedge clk);
        op4 = 2'b00;
    endtask

    task automatic test_inc_oe();
        @(negedge clk);
        drv4_en = 1'b1; drv4 = 8'h10; sel4 = 2'd3; op4 = 2'b01;
        tick();
        @(negedge clk);
        drv4_en = 1'b0; op4 = 2'b10; oe4 = 1'b1;
        #1;
        checks++;
        if (bus4 !== 8'h10) begin errors++; $display("FAIL incoe_before got %h want 10", bus4); end
        tick();
        checks++;
        if (bus4 !== 8'h11) begin errors++; $display("FAIL incoe_after got %h want 11", bus4); end
        checks++;
        if (rs4 !== 32'h115A5A5B) begin errors++; $display("FAIL incoe_state got %h want 115a5a5b", rs4); end
        @(negedge clk);
        op4 = 2'b00; oe4 = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        sel4 = 2'd0; op4 = 2'b10;
        tick();
        checks++;
        if (rs4[7:0] !== 8'h5C) begin errors++; $display("FAIL b2b_inc1 got %h want 5c", rs4[7:0]); end
        tick();
        checks++;
        if (rs4[7:0] !== 8'h5D) begin errors++; $display("FAIL b2b_inc2 got %h want 5d", rs4[7:0]); end
        op4 = 2'b01; drv4_en = 1'b1; drv4 = 8'h77;
        tick();
        checks++;
        if (rs4[7:0] !== 8'h77) begin errors++; $display("FAIL b2b_load got %h want 77", rs4[7:0]); end
        op4 = 2'b11; drv4_en = 1'b0;
        tick();
        checks++;
        if (rs4 !== 32'h115A5A76 || wrap4 !== 1'b0) begin errors++; $display("FAIL b2b_dec got %h/%b want 115a5a76/0", rs4, wrap4); end
        op4 = 2'b00;
    endtask

    initial begin
        #2;
        test_reset();
        test_load();
        test_wrap();
        test_sel_err();
        test_async_reset();
        test_inc_oe();
        test_back_to_back();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_bank.md
# register_bank

Parametrised, multi-register successor to the single bus register: a bank of `NUM_REGS` registers of `DATA_W` bits sharing one tristate data bus. Each clock the selected register can be loaded from the bus, incremented or decremented, and can drive the bus. A registered wrap flag supports counters and pointers such as PC and SP. The bank sits on the CPU's internal data bus and exports all register contents flat for the datapath and debug.

## Interface
Parameters:
- `DATA_W`, 32, width of each register and of the bus.
- `NUM_REGS`, 4, number of registers; must be ≥2, need not be a power of two.
- `SEL_W`, `$clog2(NUM_REGS)`, select width.
- `RESET_VALUE`, 0, value loaded into every register on reset.

Ports:
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `oe`  in  1  drive `data_bus` with the selected register.
- `sel`  in  `SEL_W`  register index.
- `op`  in  2  operation on `sel`: 00 hold, 01 load, 10 increment, 11 decrement.
- `data_bus`  inout  `DATA_W`  shared tristate bus.
- `register_state`  out  `NUM_REGS*DATA_W`  all registers; reg i at bits [i*DATA_W +: DATA_W].
- `wrap`  out  1  registered; last executed inc/dec wrapped.
- `zero`  out  1  combinational; selected register == 0.
- `sel_err`  out  1  combinational; `sel` ≥ `NUM_REGS`.
- `bus_conflict`  out  1  combinational; `oe` and `op`==01 in the same cycle.

## Operation
- Reset (`rst`=0, any time, independent of `clk`): every register = `RESET_VALUE`, `wrap`=0. Takes effect immediately, including mid-operation. While reset is held, the bus is still driven if `oe`=1, with the reset value.
- Bus drive: when `oe`=1 and `sel` is valid, `data_bus` = reg[`sel`]. When `oe`=1 and `sel_err`=1, `data_bus` = all zeros. When `oe`=0, `data_bus` = high-Z on every bit.
- Load (01): reg[`sel`] ← `data_bus`.
- Increment (10): reg[`sel`] ← reg[`sel`]+1, modulo 2^`DATA_W`.
- Decrement (11): reg[`sel`] ← reg[`sel`]−1, modulo 2^`DATA_W`.
- Hold (00): no register changes.
- Only reg[`sel`] ever changes; all other registers hold.
- `wrap`:
  - Updated only on edges that execute inc or dec.
  - Set to 1 on inc from all-ones to 0, or dec from 0 to all-ones.
  - Otherwise cleared to 0 on those edges.
  - Hold, load, suppressed ops and `sel_err` cycles leave `wrap` unchanged.
- Load with `oe`=1 (self-loop, `bus_conflict`=1): load is suppressed and the register holds. Inc/dec with `oe`=1 are legal; the bus shows the pre-edge value.
- `sel_err`=1: op is ignored, with no register or `wrap` change.
- `zero` reads 0 when `sel_err`=1.
- Bus contention with external drivers is the bus master's responsibility and is not detected here.

## Timing
- Load/inc/dec latency: 1 cycle. The new value appears on `register_state` and on the bus (if `oe`) after the rising edge where the op was sampled.
- `oe`→bus, `sel`→bus/`zero`/`sel_err`: combinational, same cycle.
- `wrap` valid from the edge executing the wrapping op until the next executed inc/dec or reset.
- Reset release: first edge with `rst`=1 executes normally; no dead cycle.
- Back-to-back ops on the same register every cycle are supported, e.g. inc, inc, load, dec on consecutive edges.

## Test plan
- Reset then release: with `DATA_W`=8, `NUM_REGS`=4, `RESET_VALUE`=8'h5A, `register_state`=32'h5A5A5A5A and `wrap`=0. With `oe`=0, `data_bus`=Z.
- Load and read: drive 8'h3C, `sel`=2, op=01, one edge, then `oe`=1 with bus released → bus=8'h3C, reg2=8'h3C, regs 0/1/3 unchanged. Load with `oe`=1 → register unchanged and `bus_conflict`=1.
- Wrap: reg1=8'hFE, inc ×2 → 8'hFF with `wrap`=0, then 8'h00 with `wrap`=1 and `zero`=1. One hold edge → `wrap` still 1. Dec → 8'hFF, `wrap`=1. Dec → 8'hFE, `wrap`=0.
- Invalid select: `NUM_REGS`=3, `sel`=3, op=10, `oe`=1 → `sel_err`=1, bus=8'h00, no register or `wrap` change.
- Async reset mid-stream: inc reg0 every cycle, assert `rst`=0 between edges → all registers = `RESET_VALUE` before the next edge. After release, the inc resumes from `RESET_VALUE` (8'h5A→8'h5B).
- Inc with `oe`=1 on reg3=8'h10 → bus shows 8'h10 before the edge and 8'h11 after.
